// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter and the pipeline controller:
//   - arbiter state encodings (legacy-compatible 2-bit constants)
//   - stall polarity (STOP / NO_STOP), shared with pipeline ctrl
//   - bus error source codes
//   - the registered bus command record and a stall helper
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    // Arbiter FSM encodings
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_DBUS = 2'd1;
    localparam logic [1:0] ARB_IBUS = 2'd2;

    // Stall request polarity seen by the pipeline controller
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // bus_err_src codes
    localparam logic ERR_SRC_IF  = 1'b0;
    localparam logic ERR_SRC_MEM = 1'b1;

    // Bus command captured at grant and held for the whole bus cycle
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    // A requester stalls until its own transaction completes this cycle
    function automatic logic stall_of(input logic req, input logic done);
        return (req && !done) ? STOP : NO_STOP;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SRAM-style bus between instruction fetch (IF) and load/store (MEM).
// MEM has fixed priority over IF; a grant is held until bus_ack or timeout and
// is never preempted. A flush during a fetch discards that fetch's result.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   flush_i                  pipeline flush; kills a pending fetch result
//   if_req/if_addr           fetch request (read-only)
//   if_rdata                 fetch data, valid when if_req && !stallreq_from_if
//   stallreq_from_if         fetch not yet complete
//   mem_req/we/sel/addr/wdata  data request
//   mem_rdata                load data, valid when mem_req && !stallreq_from_mem
//   stallreq_from_mem        data access not yet complete
//   bus_req/we/sel/addr/wdata  bus command (registered at grant)
//   bus_rdata, bus_ack       bus response, one-cycle ack strobe
//   bus_err, bus_err_src     one-cycle timeout abort pulse and its source
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        stallreq_from_if,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stallreq_from_mem,

    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic        bus_err_src
);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic             discard;
    bus_cmd_t         cmd;

    logic busy;
    logic timeout;
    logic done;
    logic mem_done;
    logic if_done;

    assign busy    = (state == ARB_DBUS) || (state == ARB_IBUS);
    assign timeout = busy && (cnt == CNT_W'(TIMEOUT - 1));
    assign done    = busy && (bus_ack || timeout);

    // A discarded fetch still finishes on the bus but never reports completion
    assign mem_done = (state == ARB_DBUS) && done;
    assign if_done  = (state == ARB_IBUS) && !discard && done;

    // Next state: MEM wins in IDLE; a flushing fetch is not started
    always_comb begin
        // NOTE: default assignment first so every path drives state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            ARB_IDLE: begin
                if (mem_req)
                    state_nx = ARB_DBUS;
                else if (if_req && !flush_i)
                    state_nx = ARB_IBUS;
            end
            ARB_DBUS, ARB_IBUS: begin
                if (done)
                    state_nx = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            state   <= ARB_IDLE;
            cnt     <= '0;
            discard <= 1'b0;
        end else begin
            state <= state_nx;
            // Counter sits at zero while idle, so the first busy cycle sees 0
            if (state == ARB_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            // discard accumulates flushes for the running fetch, cleared on leaving IBUS
            if ((state == ARB_IBUS) && !done)
                discard <= discard | flush_i;
            else
                discard <= 1'b0;
        end
    end

    // Command capture: loaded every idle cycle, so it holds the granted
    // request's fields for the whole bus cycle.
    // NOTE: datapath-only register, deliberately not reset; bus_req qualifies it.
    always_ff @(posedge clk) begin
        if (state == ARB_IDLE) begin
            if (mem_req) begin
                cmd.we    <= mem_we;
                cmd.sel   <= mem_sel;
                cmd.addr  <= mem_addr;
                cmd.wdata <= mem_wdata;
            end else begin
                cmd.we    <= 1'b0;
                cmd.sel   <= 4'hF;
                cmd.addr  <= if_addr;
                cmd.wdata <= '0;
            end
        end
    end

    assign bus_req   = busy;
    assign bus_we    = cmd.we;
    assign bus_sel   = cmd.sel;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;

    assign stallreq_from_mem = stall_of(mem_req, mem_done);
    assign stallreq_from_if  = stall_of(if_req, if_done);

    // Data only on ack; a timeout completes with zero data
    assign mem_rdata = (mem_done && bus_ack) ? bus_rdata : 32'h0;
    assign if_rdata  = (if_done && bus_ack) ? bus_rdata : 32'h0;

    // Abort pulse; suppressed for a discarded fetch
    assign bus_err     = timeout && !bus_ack && !((state == ARB_IBUS) && discard);
    assign bus_err_src = (bus_err && (state == ARB_DBUS)) ? ERR_SRC_MEM : ERR_SRC_IF;

endmodule
